writeback_regfile: RTL and testbench



---
 rtl/wb_pkg.sv | 41 ++++
 rtl/regfile_2r1w.sv | 50 +++++
 rtl/writeback_regfile.sv | 82 ++++++++
 tb/tb_writeback_regfile.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants for the writeback stage.
//   - datapath/regfile/counter sizes
//   - opcode encodings and instruction field bit positions
//   - is_reg_write(): true for opcodes that commit a register result
package wb_pkg;

  localparam int WB_DATA_W = 20;
  localparam int WB_NREGS  = 16;
  localparam int WB_CNT_W  = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam int OPC_HI = 19;
  localparam int OPC_LO = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 12;
  localparam int RS_HI  = 11;
  localparam int RS_LO  = 8;
  localparam int RT_HI  = 7;
  localparam int RT_LO  = 4;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Reserved codes fall into the default arm and never write.
  function automatic logic is_reg_write(input logic [3:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LW: is_reg_write = 1'b1;
      default:                                       is_reg_write = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREGS x DATA_W register file, two combinational read ports,
// one synchronous write port.
//   clock, reset        : rising-edge clock, synchronous active-high clear
//   we, waddr, wdata    : write port (writes to address 0 are dropped)
//   rmask               : forces both read ports to zero
//   raddr_a/b, rdata_a/b: read ports; R0 reads 0, a same-cycle write to the
//                         addressed register is bypassed onto the port
module regfile_2r1w
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int NREGS  = WB_NREGS,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rmask,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [NREGS-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clock) begin
    if (reset)
      mem_q <= '0;
    else if (we && (waddr != '0))
      mem_q[waddr] <= wdata;
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [AW-1:0] a);
    if (rmask || (a == '0))
      rd_port = '0;
    else if (we && (waddr == a))
      rd_port = wdata;
    else
      rd_port = mem_q[a];
  endfunction

  always_comb begin
    rdata_a = rd_port(raddr_a);
    rdata_b = rd_port(raddr_b);
  end

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback stage + architectural register file.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   wb_valid         : MEM/WB slot holds a real instruction
//   wb_instruction   : propagated instruction (ignored on bubbles)
//   wb_alu_result    : ALU result, source for all writing ops except LW
//   wb_mem_data      : memory read data, source for LW
//   rd_addr_a/b      : decode read addresses
//   rd_data_a/b      : decode read data (bypassed, R0 = 0)
//   fwd_we/dest/data : WB forwarding bus, all zero when not writing
//   retired_count    : valid instructions seen since reset (wraps)
module writeback_regfile
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int NREGS  = WB_NREGS,
  parameter int CNT_W  = WB_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_instruction,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [3:0]        rd_addr_a,
  input  logic [3:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              fwd_we,
  output logic [3:0]        fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_count
);

  logic [3:0]        opcode;
  logic [3:0]        rd;
  logic [DATA_W-1:0] wsrc;
  logic              we;
  logic              rst_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign opcode = wb_instruction[OPC_HI:OPC_LO];
  assign rd     = wb_instruction[RD_HI:RD_LO];
  assign wsrc   = (opcode == OP_LW) ? wb_mem_data : wb_alu_result;

  // wb_valid gates first so X instruction bits on bubbles cannot leak out.
  assign we = wb_valid && is_reg_write(opcode) && (rd != 4'd0) && !reset;

  always_comb begin
    fwd_we   = we;
    fwd_dest = we ? rd   : 4'd0;
    fwd_data = we ? wsrc : '0;
  end

  // Reads are held at zero through reset and the cycle following it.
  always_ff @(posedge clock) rst_q <= reset;

  regfile_2r1w #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(4)) u_rf (
    .clock   (clock),
    .reset   (reset),
    .we      (we),
    .waddr   (rd),
    .wdata   (wsrc),
    .rmask   (reset | rst_q),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (rd_data_a),
    .rdata_b (rd_data_b)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (wb_valid) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign retired_count = cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [19:0] wb_instruction, wb_alu_result, wb_mem_data;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [19:0] rd_data_a, rd_data_b, fwd_data;
  logic        fwd_we;
  logic [3:0]  fwd_dest;
  logic [15:0] retired_count;

  writeback_regfile dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid),
    .wb_instruction(wb_instruction), .wb_alu_result(wb_alu_result),
    .wb_mem_data(wb_mem_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .fwd_we(fwd_we),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [3:0]  dest;
    logic [19:0] data;
    logic [19:0] ra;
    logic [19:0] rb;
  } exp_t;

  exp_t        sb[$];
  logic [19:0] mrf[16];
  logic [15:0] mcnt;
  logic        mpost;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] rd);
    return {op, rd, 12'h000};
  endfunction

  // One clock: drive at negedge, push expectation, compare combinational
  // outputs before the edge, then advance model and check the counter.
  task automatic cyc(input logic rst, input logic v, input logic [19:0] ins,
                     input logic [19:0] alu, input logic [19:0] mem,
                     input logic [3:0] ra, input logic [3:0] rb, input string tag);
    exp_t e, o;
    logic       w;
    logic [19:0] d;
    @(negedge clock);
    reset = rst; wb_valid = v; wb_instruction = ins;
    wb_alu_result = alu; wb_mem_data = mem; rd_addr_a = ra; rd_addr_b = rb;
    w = !rst && v && (ins[19:16] <= 4'd5) && (ins[15:12] != 4'd0);
    d = (ins[19:16] == 4'd5) ? mem : alu;
    e.we   = w;
    e.dest = w ? ins[15:12] : 4'd0;
    e.data = w ? d : 20'd0;
    e.ra = (rst || mpost || ra == 0) ? 20'd0 : (w && ins[15:12] == ra) ? d : mrf[ra];
    e.rb = (rst || mpost || rb == 0) ? 20'd0 : (w && ins[15:12] == rb) ? d : mrf[rb];
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    chk({tag, ".we"},   {31'd0, fwd_we}, {31'd0, o.we});
    chk({tag, ".dest"}, {28'd0, fwd_dest}, {28'd0, o.dest});
    chk({tag, ".data"}, {12'd0, fwd_data}, {12'd0, o.data});
    chk({tag, ".rda"},  {12'd0, rd_data_a}, {12'd0, o.ra});
    chk({tag, ".rdb"},  {12'd0, rd_data_b}, {12'd0, o.rb});
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 16; i++) mrf[i] = 20'd0;
      mcnt = 16'd0;
    end else begin
      if (w) mrf[ins[15:12]] = d;
      if (v) mcnt = mcnt + 16'd1;
    end
    mpost = rst;
    #1;
    chk({tag, ".cnt"}, {16'd0, retired_count}, {16'd0, mcnt});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mrf[i] = 20'd0;
    mcnt = 16'd0; mpost = 1'b0;
    reset = 1'b1; wb_valid = 1'b0; wb_instruction = '0;
    wb_alu_result = '0; wb_mem_data = '0; rd_addr_a = '0; rd_addr_b = '0;

    cyc(1, 0, mk(4'hF, 0), 0, 0, 1, 2, "rst0");
    cyc(1, 0, mk(4'hF, 0), 0, 0, 3, 4, "rst1");
    cyc(0, 0, mk(4'hF, 0), 0, 0, 5, 6, "post");
    for (int i = 0; i < 16; i++)
      cyc(0, 0, mk(4'hF, 0), 0, 0, i[3:0], 4'(15 - i), "rdall");

    // ADD r3 with bypass on port A, then array read next cycle
    cyc(0, 1, mk(4'h0, 3), 20'h12345, 0, 3, 0, "add3");
    cyc(0, 0, mk(4'hF, 0), 0, 0, 3, 3, "rd3");
    // LW r5 takes memory data; SW afterwards leaves r5 alone
    cyc(0, 1, mk(4'h5, 5), 20'h00010, 20'hABCDE, 5, 3, "lw5");
    cyc(0, 1, mk(4'h6, 5), 20'h00020, 20'h11111, 5, 5, "sw5");
    cyc(0, 0, mk(4'hF, 0), 0, 0, 5, 5, "rd5");
    // R0 write dropped; bubble with ADD r4 ignored
    cyc(0, 1, mk(4'h0, 0), 20'hFFFFF, 0, 0, 0, "add0");
    cyc(0, 0, mk(4'h0, 4), 20'h0BEEF, 0, 4, 0, "bub4");
    cyc(0, 0, mk(4'hF, 0), 0, 0, 4, 0, "rd4");
    // Other opcodes incl. reserved and NOP
    cyc(0, 1, mk(4'h1, 6), 20'h00AAA, 20'h55555, 6, 6, "sub6");
    cyc(0, 1, mk(4'h4, 8), 20'h7777F, 0, 8, 6, "addi8");
    cyc(0, 1, mk(4'hA, 9), 20'h22222, 0, 9, 8, "rsv9");
    cyc(0, 1, mk(4'h7, 9), 20'h33333, 0, 9, 9, "beq9");
    cyc(0, 1, mk(4'hF, 0), 0, 0, 8, 6, "nop");
    // Back-to-back R7 writes, both ports on R7
    cyc(0, 1, mk(4'h2, 7), 20'h00001, 0, 7, 7, "b2b1");
    cyc(0, 1, mk(4'h3, 7), 20'h00002, 0, 7, 7, "b2b2");
    cyc(0, 0, mk(4'hF, 0), 0, 0, 7, 7, "b2b3");
    // Reset with a pending ADD r2
    cyc(0, 1, mk(4'h0, 2), 20'h0F0F0, 0, 2, 0, "pre2");
    cyc(1, 1, mk(4'h0, 2), 20'h54321, 0, 2, 2, "rstadd");
    cyc(0, 0, mk(4'hF, 0), 0, 0, 2, 3, "postrst");
    cyc(0, 0, mk(4'hF, 0), 0, 0, 2, 3, "rd2");

    // Counter wrap: 0xFFFF retired, then one more
    for (int i = 0; i < 16'hFFFF; i++) begin
      @(negedge clock);
      reset = 1'b0; wb_valid = 1'b1; wb_instruction = mk(4'hF, 0);
      @(posedge clock);
      mcnt = mcnt + 16'd1;
    end
    #1;
    chk("cnt_ffff", {16'd0, retired_count}, 32'h0000FFFF);
    cyc(0, 1, mk(4'hF, 0), 0, 0, 0, 0, "wrap");
    chk("cnt_wrap", {16'd0, retired_count}, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
